alu_seq: RTL
============

# alu_seq

Parametrised, handshaked, sequential ALU; the next generation of the team's 4-bit combinational `alu_block`. It adds:
- configurable operand width;
- a 3-bit opcode set with status flags;
- a multi-cycle shift-add multiplier;
- valid/ready flow control on both input and output.

It sits between an operand/instruction source and a result consumer, and accepts one operation at a time.

## Interface
- `WIDTH`, default 8: operand/result width; legal range 4..32.
- `clk` input 1: clock, rising-edge active.
- `rst` input 1: asynchronous reset, active-high.
- `in_valid` input 1: operation presented.
- `in_ready` output 1: block can accept; equals 1 only in IDLE.
- `a`, `b` input WIDTH: operands, sampled on accept.
- `op` input 3: 000 ADD, 001 SUB, 010 CMP, 011 AND, 100 OR, 101 XOR, 110 MUL, 111 illegal.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer takes the result.
- `result` output WIDTH: result, low half for MUL.
- `result_hi` output WIDTH: high product half for MUL; 0 for all other ops.
- `carry` output 1: ADD carry-out; SUB borrow (1 when a < b unsigned); 0 otherwise.
- `ovf` output 1: signed overflow for ADD/SUB; 0 otherwise.
- `zero` output 1: all result bits zero; for MUL this covers both `result_hi` and `result`.
- `err` output 1: illegal opcode, or MUL issued while compiled out.

## Operation
- FSM states:
  - IDLE. On `in_valid`, latch `a`, `b`, `op`. MUL goes to BUSY; every other op computes and goes to DONE.
  - BUSY. Shift-add multiply, one multiplier bit per cycle, WIDTH iterations, then DONE.
  - DONE. Outputs are registered and held stable while `out_valid` = 1. On `out_ready`, return to IDLE.
- `in_ready` = (state == IDLE). There is no accept in the same cycle a result is consumed, so peak throughput is 1 op per 2 cycles.
- ADD/SUB: WIDTH-bit modulo result. Signed overflow is computed from the operand and result MSBs.
- CMP, unsigned: `result` = {0…0, gt, lt, eq} in bits [2:0]; all flags except `zero` are 0.
- AND/OR/XOR: bitwise; `carry` = `ovf` = 0.
- MUL, unsigned: 2·WIDTH-bit product as {`result_hi`, `result`}.
- Illegal op: `result` = `result_hi` = 0, `zero` = 1, `err` = 1, latency 1.
- Output registers update only on the transition into DONE. They keep their values after consumption, but `out_valid` deasserts.
- `in_valid` while not in IDLE is ignored, with no side effects.

## Timing
- Reset values:
  - `in_ready` = 1.
  - `out_valid`, `result`, `result_hi`, `carry`, `ovf`, `zero`, `err` = 0.
  - State = IDLE; the iteration counter is cleared.
- Accept edge: the rising edge with `in_valid` && `in_ready`.
- Non-MUL latency: `out_valid` = 1 after the first edge following accept.
- MUL latency: `out_valid` = 1 after edge WIDTH+1 following accept; `in_ready` stays 0 throughout.
- Backpressure: with `out_ready` = 0, DONE holds indefinitely and all outputs stay stable.
- Consume edge: `out_valid` && `out_ready`. The next cycle has `out_valid` = 0 and `in_ready` = 1.
- Reset mid-BUSY or mid-DONE: the operation is aborted immediately (asynchronous) and is not resumed after release.
- `out_ready` asserted while `out_valid` = 0 has no effect.

## Configuration
- `ALU_SEQ_MUL_EN` defined: BUSY state, counter and multiplier datapath are present; MUL behaves as above.
- Not defined: BUSY is absent. Op 110 is treated as illegal (latency 1, `err` = 1, results 0), and `in_ready` never stalls beyond DONE.

## Test plan
- WIDTH=8, ADD `a`=0xC8, `b`=0x64 → `result` 0x2C, `carry` 1, `ovf` 0, `zero` 0, `out_valid` 1 edge after accept.
- SUB `a`=0x03, `b`=0x0C → `result` 0xF7, `carry` 1, `ovf` 0. SUB `a`=0x80, `b`=0x01 → `result` 0x7F, `ovf` 1.
- CMP `a`=0x0C, `b`=0x03 → `result` 0x04.
  - CMP `a`=`b`=0x55 → `result` 0x01.
  - AND 0x0C,0x03 → `result` 0x00, `zero` 1.
- MUL (macro on) 0x0F × 0x11 → `result_hi` 0x00, `result` 0xFF, `out_valid` 9 edges after accept, `in_ready` 0 meanwhile.
  - 0xFF × 0xFF → 0xFE / 0x01.
  - Macro off: `err` 1 after 1 edge.
- Backpressure: hold `out_ready` = 0 for 5 cycles after XOR 0xAA,0xFF → `result` 0x55 stable, `in_ready` 0, and an extra `in_valid` is ignored. Release → `in_ready` 1 the next cycle.
- Assert `rst` 4 cycles into MUL → all outputs 0 and `in_ready` 1 immediately. A following ADD 1+1 returns 0x02.
- Op 111 → `err` 1, `zero` 1, `result` 0.

Source files
------------

// File: rtl/alu_seq_if.sv
// Handshake and operand/result bundle for alu_seq.
// master = operation source / result consumer side, slave = the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             carry;
    logic             ovf;
    logic             zero;
    logic             err;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, result_hi, carry, ovf, zero, err
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, result_hi, carry, ovf, zero, err
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU, one operation in flight at a time.
// Optional feature macro ALU_SEQ_MUL_EN: when defined, adds the BUSY state,
// an iteration down-counter and a shift-add multiplier for op 110. When not
// defined, op 110 is reported as illegal with single-cycle latency.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | in_ready=1, waiting for in_valid; operands sampled on accept
// BUSY  | multiply in progress, one multiplier bit per cycle (MUL only)
// DONE  | out_valid=1, outputs held until out_ready
module alu_seq #(
    parameter int WIDTH = 8
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_CMP = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

    state_t state;
    state_t next_state;

    logic             mul_sel;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;
    logic             alu_err;

    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_hi_q;
    logic             carry_q;
    logic             ovf_q;
    logic             zero_q;
    logic             err_q;

`ifdef ALU_SEQ_MUL_EN
    // prod holds {partial product high half, remaining multiplier bits}
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     prod_add;
    logic [2*WIDTH-1:0] prod_next;
    logic               last_iter;

    // One shift-add step: conditionally add multiplicand, then shift right.
    always_comb begin
        prod_add  = {1'b0, prod[2*WIDTH-1:WIDTH]};
        if (prod[0]) begin
            prod_add = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        end
        prod_next = {prod_add, prod[WIDTH-1:1]};
        last_iter = (cnt == CW'(1));
    end

    assign mul_sel = (bus.op == OP_MUL);
`else
    assign mul_sel = 1'b0;
`endif

    // Single-cycle ALU on the live operands; only captured on accept.
    always_comb begin
        sum       = {1'b0, bus.a} + {1'b0, bus.b};
        diff      = {1'b0, bus.a} - {1'b0, bus.b};
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        case (bus.op)
            OP_ADD: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                            (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = diff[WIDTH-1:0];
                alu_carry = diff[WIDTH];
                alu_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                            (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_CMP: alu_res = {{(WIDTH-3){1'b0}}, (bus.a > bus.b), (bus.a < bus.b), (bus.a == bus.b)};
            OP_AND: alu_res = bus.a & bus.b;
            OP_OR:  alu_res = bus.a | bus.b;
            OP_XOR: alu_res = bus.a ^ bus.b;
            default: alu_err = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
`ifdef ALU_SEQ_MUL_EN
                    next_state = mul_sel ? BUSY : DONE;
`else
                    next_state = DONE;
`endif
                end
            end
`ifdef ALU_SEQ_MUL_EN
            BUSY: begin
                if (last_iter) begin
                    next_state = DONE;
                end
            end
`endif
            DONE: begin
                if (bus.out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    // Operand capture, multiplier iteration and output registers; outputs
    // only change on the edge that enters DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q    <= '0;
            result_hi_q <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            cnt         <= '0;
            mcand       <= '0;
            prod        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (mul_sel) begin
`ifdef ALU_SEQ_MUL_EN
                            mcand <= bus.a;
                            prod  <= {{WIDTH{1'b0}}, bus.b};
                            cnt   <= CW'(WIDTH);
`endif
                        end else begin
                            result_q    <= alu_res;
                            result_hi_q <= '0;
                            carry_q     <= alu_carry;
                            ovf_q       <= alu_ovf;
                            zero_q      <= (alu_res == '0);
                            err_q       <= alu_err;
                        end
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                BUSY: begin
                    prod <= prod_next;
                    cnt  <= cnt - CW'(1);
                    if (last_iter) begin
                        result_q    <= prod_next[WIDTH-1:0];
                        result_hi_q <= prod_next[2*WIDTH-1:WIDTH];
                        carry_q     <= 1'b0;
                        ovf_q       <= 1'b0;
                        zero_q      <= (prod_next == '0);
                        err_q       <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.carry     = carry_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.err       = err_q;

endmodule
